// File: rtl/key_repeat_ctrl.sv
// key_repeat_ctrl
//   Turns the per-key "held" levels from the keyboard decoder into the
//   single-cycle action pulses consumed by game_control.
//   - left/right : delayed auto-shift, then auto-repeat; last-pressed wins
//   - down       : pulse on press, then fixed-rate repeat while held
//   - rotate/drop: one pulse per press
//   A key that is already held when reset deasserts, or when en rises,
//   is ignored until it has been released.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   en           game accepting input (low = paused / game over)
//   held_left    left key held level (synchronous to clk)
//   held_right   right key held level
//   held_down    down key held level
//   held_rotate  rotate key held level
//   held_drop    hard-drop key held level
//   key_left     one-cycle move-left pulse (registered)
//   key_right    one-cycle move-right pulse (registered)
//   key_down     one-cycle soft-drop pulse (registered)
//   key_rotate   one-cycle rotate pulse (registered)
//   key_drop     one-cycle hard-drop pulse (registered)
module key_repeat_ctrl #(
  parameter int DAS_CYCLES  = 16_000_000,
  parameter int ARR_CYCLES  = 5_000_000,
  parameter int SOFT_CYCLES = 4_000_000,
  parameter int CNT_W       = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic held_left,
  input  logic held_right,
  input  logic held_down,
  input  logic held_rotate,
  input  logic held_drop,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DAS    = 2'd1,
    REPEAT = 2'd2
  } lr_state_t;

  typedef struct packed {
    lr_state_t        st;
    logic [CNT_W-1:0] cnt;
    logic             live;   // this key owns a recognised, still-held press
    logic             pulse;
  } lr_t;

  // Key vector order: {left, right, down, rotate, drop}
  logic [4:0] held_v;
  logic [4:0] armed_v;
  logic [4:0] press_v;

  lr_state_t        st_l, st_r;
  logic [CNT_W-1:0] cnt_l, cnt_r, cnt_d;
  logic             live_l, live_r;
  logic             run_d;
  lr_t              nxt_l, nxt_r;

  assign held_v  = {held_left, held_right, held_down, held_rotate, held_drop};
  assign press_v = held_v & armed_v & {5{en}};

  // Next state of one horizontal direction.
  //   other_press : the opposite direction is recognising a press this cycle
  //   wins_tie    : this direction wins a same-cycle press of both
  //   other_owns  : the opposite direction holds a live press
  // A direction that loses to the other keeps its live flag while held, so
  // it can take over (DAS restarted, no immediate pulse) when the other is
  // released.
  function automatic lr_t lr_next(
    input lr_state_t        st,
    input logic [CNT_W-1:0] cnt,
    input logic             live,
    input logic             held,
    input logic             press,
    input logic             other_press,
    input logic             wins_tie,
    input logic             other_owns,
    input logic             en_i
  );
    lr_t n;
    n.st    = st;
    n.cnt   = cnt;
    n.live  = live;
    n.pulse = 1'b0;
    if (!en_i || !held) begin
      n.st   = IDLE;
      n.cnt  = '0;
      n.live = 1'b0;
    end else if (other_press && !(press && wins_tie)) begin
      n.st   = IDLE;
      n.cnt  = '0;
      n.live = live | press;
    end else if (press) begin
      n.st    = DAS;
      n.cnt   = '0;
      n.live  = 1'b1;
      n.pulse = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          if (live && !other_owns) begin
            n.st  = DAS;
            n.cnt = '0;
          end
        end
        DAS: begin
          if (cnt == CNT_W'(DAS_CYCLES - 1)) begin
            n.st    = REPEAT;
            n.cnt   = '0;
            n.pulse = 1'b1;
          end else begin
            n.cnt = cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (cnt == CNT_W'(ARR_CYCLES - 1)) begin
            n.cnt   = '0;
            n.pulse = 1'b1;
          end else begin
            n.cnt = cnt + 1'b1;
          end
        end
        default: begin
          n.st  = IDLE;
          n.cnt = '0;
        end
      endcase
    end
    return n;
  endfunction

  always_comb begin
    nxt_l = lr_next(st_l, cnt_l, live_l, held_left, press_v[4], press_v[3],
                    1'b0, held_right & live_r, en);
    nxt_r = lr_next(st_r, cnt_r, live_r, held_right, press_v[3], press_v[4],
                    1'b1, held_left & live_l, en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_v    <= '0;
      st_l       <= IDLE;
      st_r       <= IDLE;
      cnt_l      <= '0;
      cnt_r      <= '0;
      cnt_d      <= '0;
      live_l     <= 1'b0;
      live_r     <= 1'b0;
      run_d      <= 1'b0;
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_down   <= 1'b0;
      key_rotate <= 1'b0;
      key_drop   <= 1'b0;
    end else begin
      // Re-armed by a low sample; consumed by a recognised press or by
      // being held while en is low.
      armed_v <= ~held_v | ({5{en}} & armed_v & ~press_v);

      st_l      <= nxt_l.st;
      cnt_l     <= nxt_l.cnt;
      live_l    <= nxt_l.live;
      key_left  <= nxt_l.pulse;
      st_r      <= nxt_r.st;
      cnt_r     <= nxt_r.cnt;
      live_r    <= nxt_r.live;
      key_right <= nxt_r.pulse;

      if (!en || !held_down) begin
        run_d    <= 1'b0;
        cnt_d    <= '0;
        key_down <= 1'b0;
      end else if (press_v[2]) begin
        run_d    <= 1'b1;
        cnt_d    <= '0;
        key_down <= 1'b1;
      end else if (run_d && cnt_d == CNT_W'(SOFT_CYCLES - 1)) begin
        cnt_d    <= '0;
        key_down <= 1'b1;
      end else begin
        cnt_d    <= run_d ? cnt_d + 1'b1 : '0;
        key_down <= 1'b0;
      end

      key_rotate <= press_v[1];
      key_drop   <= press_v[0];
    end
  end

endmodule
